fpu_arbiter: RTL
================

Name: fpu_arbiter

Overview:
- Shares one fpu instance among N_REQ requesters using round-robin arbitration.
- Each requester has a valid/ready request channel and receives a one-cycle response pulse.
- The fpu has no start/done handshake and free-runs its EXPO→ADD_SUB→CORRIGE→READY loop. The arbiter therefore holds operands stable for HOLD_CYCLES, then samples the fpu outputs.
- Sits between the execution-unit requesters and the single fpu.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 64, cycles operands are held before sampling; covers two worst-case fpu passes; minimum 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i]
- req_a  in  32*N_REQ  operand A; requester i occupies bits [32i+31:32i]
- req_b  in  32*N_REQ  operand B, same packing as req_a
- req_op  in  2*N_REQ  op code; requester i occupies bits [2i+1:2i]
- resp_valid  out  N_REQ  one-hot, one-cycle response pulse to the owning requester
- resp_data  out  32  captured fpu result
- resp_status  out  4  captured fpu status (one-hot: 0001 exact, 0010 inexact, 0100 overflow, 1000 underflow)
- busy  out  1  high in WAIT and RESP
- fpu_a, fpu_b  out  32 each  operands driven to the fpu
- fpu_op  out  2  op driven to the fpu
- fpu_data  in  32  fpu data_out
- fpu_status  in  4  fpu status_out

Behaviour:
- Reset values: all registered outputs 0; state IDLE; RR pointer 0; counter 0.
- Reset mid-operation aborts the transaction silently. No resp_valid is issued; requesters must re-request.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: one-hot on the first asserted req_valid at or after the RR pointer (wrapping). Otherwise 0.
  - On accept in cycle T: latch the winner's operands into fpu_a/fpu_b/fpu_op, latch winner id, load counter = HOLD_CYCLES-1, go to WAIT.
- WAIT (cycles T+1 .. T+HOLD_CYCLES):
  - req_ready = 0; fpu_a/fpu_b/fpu_op held constant.
  - Counter decrements each cycle.
  - In the cycle counter==0: capture fpu_data/fpu_status into resp_data/resp_status, go to RESP.
- RESP (cycle T+HOLD_CYCLES+1):
  - resp_valid[id] = 1 for exactly one cycle.
  - RR pointer ← (id+1) mod N_REQ; go to IDLE.
- Latency from accept to resp_valid is exactly HOLD_CYCLES+1. Minimum spacing between accepts is HOLD_CYCLES+2.
- resp_data/resp_status hold their value until the next capture. fpu_a/fpu_b/fpu_op hold their last value while IDLE.
- Requests seen in WAIT/RESP are not accepted. Requesters keep req_valid and operands stable until accepted.
- A requester that drops req_valid before acceptance loses nothing; no state is kept for it.
- Simultaneous requests are resolved by the RR pointer only. With all N_REQ asserted continuously, grants rotate 0,1,..,N_REQ-1,0.
- Pointer wrap: id N_REQ-1 wraps the pointer to 0.
- The counter is sized $clog2(HOLD_CYCLES) bits; it never underflows (state leaves WAIT at 0).

Optional Feature:
- Macro: FPU_ARB_PRIO0_EN.
- Defined: requester 0 has fixed highest priority. If req_valid[0] is asserted in IDLE it always wins. The RR pointer applies only among requesters 1..N_REQ-1, and a req-0 grant does not move the pointer.
- Undefined: pure round-robin as above.

Decomposition:
- Package fpu_arb_pkg holds:
  - state enum arb_state_t {IDLE, WAIT, RESP};
  - status localparams ST_EXACT=4'b0001, ST_INEXACT=4'b0010, ST_OVERFLOW=4'b0100, ST_UNDERFLOW=4'b1000;
  - op-code localparams.
- Sub-module rr_arbiter: parameter N, inputs req and ptr, outputs one-hot gnt and gnt_id; purely combinational.
- fpu_arbiter instantiates rr_arbiter. It does not instantiate the fpu; the fpu is connected at the top level.

Test Plan:
- Bench uses a stub fpu: fpu_data = fpu_a ^ fpu_b, fpu_status = 0001; HOLD_CYCLES=8 except where noted.
- Single request: req_valid=0001, a=0x3F000000, b=0x00000001 → accept at T; resp_valid=0001 at T+9 for 1 cycle; resp_data=0x3F000001; resp_status=0001.
- All four requesting continuously → grant order 0,1,2,3,0; accepts exactly 10 cycles apart; each resp_valid carries the matching id and operands.
- Request during WAIT: req 2 raised at T+3 → req_ready[2]=0 until IDLE at T+10; accepted at T+10.
- Reset asserted at T+4 → all outputs 0 immediately, no resp_valid; new request after release accepted in the first IDLE cycle with pointer 0.
- FPU_ARB_PRIO0_EN defined, req_valid=1111 held → requester 0 wins every arbitration; undefined → 0,1,2,3 rotation.
- HOLD_CYCLES=2 → resp_valid at T+3; back-to-back accepts 4 cycles apart.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the fpu request arbiter.
// State encoding, fpu status codes and op codes.
package fpu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [3:0] ST_EXACT     = 4'b0001;
  localparam logic [3:0] ST_INEXACT   = 4'b0010;
  localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
  localparam logic [3:0] ST_UNDERFLOW = 4'b1000;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

endpackage

// File: rtl/fpu_arbiter_if.sv
// Requester-side bundle of the fpu arbiter.
// master: requesters, slave: arbiter.
interface fpu_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic [2*N_REQ-1:0]  req_op;
  logic [N_REQ-1:0]    resp_valid;
  logic [31:0]         resp_data;
  logic [3:0]          resp_status;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_op,
    input  req_ready,
    input  resp_valid,
    input  resp_data,
    input  resp_status
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_op,
    output req_ready,
    output resp_valid,
    output resp_data,
    output resp_status
  );

endinterface

// File: rtl/fpu_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// First asserted req at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);

  logic found;
  int   idx;

  // scan from ptr upward, wrapping, keep the first hit
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one free-running fpu among N_REQ requesters.
// FPU_ARB_PRIO0_EN: requester 0 gets fixed top priority.
import fpu_arb_pkg::*;

module fpu_arbiter #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  fpu_arbiter_if.slave rq,
  output logic         busy,
  output logic [31:0]  fpu_a,
  output logic [31:0]  fpu_b,
  output logic [1:0]   fpu_op,
  input  logic [31:0]  fpu_data,
  input  logic [3:0]   fpu_status
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0]    LAST_ID  = IW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] REQ0     = N_REQ'(1);
`ifdef FPU_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] id_q, id_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sts_q, sts_d;

  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_id;
  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_id;
  logic             idle_s, wait_s, resp_s, accept;

  assign idle_s = (state_q == IDLE);
  assign wait_s = (state_q == WAIT);
  assign resp_s = (state_q == RESP);

  assign arb_req = PRIO0 ? (rq.req_valid & ~REQ0) : rq.req_valid;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req    (arb_req),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign pick    = (PRIO0 && rq.req_valid[0]) ? REQ0 : gnt;
  assign pick_id = (PRIO0 && rq.req_valid[0]) ? '0 : gnt_id;
  assign accept  = idle_s && (|pick);

  // state and datapath registers, async active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      dat_q   <= '0;
      sts_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      dat_q   <= dat_d;
      sts_q   <= sts_d;
    end
  end

  // next state: accept, hold until counter hits 0, one response cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath: latch winner, count down, capture fpu, advance pointer
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    id_d  = id_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    dat_d = dat_q;
    sts_d = sts_q;
    unique case (1'b1)
      accept: begin
        a_d   = rq.req_a[32*int'(pick_id) +: 32];
        b_d   = rq.req_b[32*int'(pick_id) +: 32];
        op_d  = rq.req_op[2*int'(pick_id) +: 2];
        id_d  = pick_id;
        cnt_d = CNT_LOAD;
      end
      wait_s: begin
        if (cnt_q == '0) begin
          dat_d = fpu_data;
          sts_d = fpu_status;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      resp_s: begin
        if (!(PRIO0 && id_q == '0))
          ptr_d = (id_q == LAST_ID) ? '0 : id_q + IW'(1);
      end
      default: ;
    endcase
  end

  // outputs: grant only while idle, response pulse in RESP
  always_comb begin
    rq.req_ready  = '0;
    rq.resp_valid = '0;
    if (idle_s) rq.req_ready = pick;
    if (resp_s) rq.resp_valid = N_REQ'(1) << id_q;
  end

  assign busy           = !idle_s;
  assign fpu_a          = a_q;
  assign fpu_b          = b_q;
  assign fpu_op         = op_q;
  assign rq.resp_data   = dat_q;
  assign rq.resp_status = sts_q;

endmodule
